// File: rtl/mem_copy_engine.sv
// Line-granular copy engine: reads one line from the source region, writes it to the
// destination region, repeats for the requested line count, then pulses done_o.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  num_lines_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  lines_done_o,
  output logic                  strobe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rw_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  done_i
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_GAP  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  next_is_wr_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [LEN_WIDTH-1:0]  lines_q;
  logic [DATA_WIDTH-1:0] line_buf_q;

  logic launch;
  logic rd_ack;
  logic wr_ack;
  logic last_line;

  assign launch    = (state_q == S_IDLE) && start_i && (num_lines_i != '0);
  assign rd_ack    = (state_q == S_RD) && done_i;
  assign wr_ack    = (state_q == S_WR) && done_i;
  assign last_line = (lines_q + LEN_WIDTH'(1)) == count_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done_i only matters while a request is outstanding
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (num_lines_i != '0) ? S_RD : S_FIN;
        end
      end
      S_RD: begin
        if (done_i) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = next_is_wr_q ? S_WR : S_RD;
      end
      S_WR: begin
        if (done_i) begin
          state_d = last_line ? S_FIN : S_GAP;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Job datapath: pointers, counters and the line buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_is_wr_q <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      count_q      <= '0;
      lines_q      <= '0;
      line_buf_q   <= '0;
    end else begin
      if (launch) begin
        src_q        <= src_addr_i;
        dst_q        <= dst_addr_i;
        count_q      <= num_lines_i;
        lines_q      <= '0;
        next_is_wr_q <= 1'b0;
      end
      if (rd_ack) begin
        line_buf_q   <= rdata_i;
        next_is_wr_q <= 1'b1;
      end
      if (wr_ack) begin
        lines_q      <= lines_q + LEN_WIDTH'(1);
        src_q        <= src_q + STRIDE;
        dst_q        <= dst_q + STRIDE;
        next_is_wr_q <= 1'b0;
      end
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally
  always_comb begin
    strobe_o     = 1'b0;
    rw_o         = 1'b0;
    addr_o       = '0;
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_FIN);
    wdata_o      = line_buf_q;
    lines_done_o = lines_q;
    case (state_q)
      S_RD: begin
        strobe_o = 1'b1;
        addr_o   = src_q;
      end
      S_WR: begin
        strobe_o = 1'b1;
        rw_o     = 1'b1;
        addr_o   = dst_q;
      end
      default: begin
        strobe_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a latency-programmable line memory answers the engine's
// requests while a scoreboard checks request order, gaps, timing and copied data.
module tb_mem_copy_engine;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int LW = 16;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] num;
    int            lat;
    bit            mid_start;
    logic [LW-1:0] exp_lines;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] src_addr_i = '0;
  logic [AW-1:0] dst_addr_i = '0;
  logic [LW-1:0] num_lines_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [LW-1:0] lines_done_o;
  logic          strobe_o;
  logic [AW-1:0] addr_o;
  logic          rw_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i = '0;
  logic          done_i;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .num_lines_i  (num_lines_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .lines_done_o (lines_done_o),
    .strobe_o     (strobe_o),
    .addr_o       (addr_o),
    .rw_o         (rw_o),
    .wdata_o      (wdata_o),
    .rdata_i      (rdata_i),
    .done_i       (done_i)
  );

  // ---------------- responder model ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            lat = 3;
  int            wait_cnt;
  logic          spur_done = 1'b0;
  logic          resp_done;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  assign resp_done = strobe_o && (wait_cnt == lat - 1);
  assign done_i    = resp_done | spur_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (strobe_o && !resp_done) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (rst_n && strobe_o && rw_o && resp_done) mem[addr_o] = wdata_o;
  end

  always @(negedge clk) rdata_i = mem_rd(addr_o);

  // ---------------- scoreboard ----------------
  logic [AW:0]   exp_q[$];
  logic [DW-1:0] exp_data[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic          prev_strobe = 1'b0;
  bit            have_prev = 0;
  int            low_cnt = 0;
  logic [AW:0]   hold_req;
  logic [DW-1:0] hold_wdata;
  logic [AW:0]   exp_req;
  int            req_cnt = 0;
  int            done_pulses = 0;
  int            busy_cycles = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (strobe_o && !prev_strobe) begin
        req_cnt++;
        check("req_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_req = exp_q.pop_front();
          check("req_rw_addr", {rw_o, addr_o}, exp_req);
        end
        if (have_prev) check("gap_cycles", low_cnt, 1);
        have_prev  = 1;
        low_cnt    = 0;
        hold_req   = {rw_o, addr_o};
        hold_wdata = wdata_o;
      end else if (strobe_o) begin
        check("hold_rw_addr", {rw_o, addr_o}, hold_req);
        if (rw_o) check("hold_wdata", wdata_o, hold_wdata);
      end
      if (!strobe_o && busy_o) low_cnt++;
      if (!busy_o) have_prev = 0;
      if (done_o) done_pulses++;
      if (busy_o) busy_cycles++;
    end
    prev_strobe = strobe_o;
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                        input logic [LW-1:0] num, input int l);
    lat = l;
    exp_data.delete();
    for (int i = 0; i < int'(num); i++) begin
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      mem[src + AW'(i * 32)] = d;
      exp_data.push_back(d);
      exp_q.push_back({1'b0, src + AW'(i * 32)});
      exp_q.push_back({1'b1, dst + AW'(i * 32)});
    end
    @(posedge clk); #1;
    start_i     = 1'b1;
    src_addr_i  = src;
    dst_addr_i  = dst;
    num_lines_i = num;
    @(posedge clk); #1;
    start_i     = 1'b0;
    src_addr_i  = $urandom;
    dst_addr_i  = $urandom;
    num_lines_i = LW'($urandom);
    @(negedge clk);
    check("launch_busy", busy_o, 1'b1);
    check("launch_strobe", strobe_o, 1'b1);
    check("launch_addr", {rw_o, addr_o}, {1'b0, src});
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge clk);
      if (done_o) ok = 1;
    end
    check("done_within_budget", ok, 1'b1);
  endtask

  task automatic run_job(input vec_t v);
    bit ok;
    int d0;
    int b0;
    d0 = done_pulses;
    b0 = busy_cycles;
    launch(v.src, v.dst, v.num, v.lat);
    if (v.mid_start) begin
      repeat (6) @(negedge clk);
      start_i     = 1'b1;
      src_addr_i  = 32'h0BAD_0000;
      dst_addr_i  = 32'h0BAD_1000;
      num_lines_i = 16'd9;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(ok);
    check("fin_busy", busy_o, 1'b1);
    check("lines_done", lines_done_o, v.exp_lines);
    @(negedge clk);
    check("post_busy", busy_o, 1'b0);
    check("post_done", done_o, 1'b0);
    check("done_pulses", done_pulses - d0, 1);
    check("busy_cycles", busy_cycles - b0, int'(v.num) * (2 * v.lat + 2));
    check("exp_q_drained", exp_q.size(), 0);
    for (int i = 0; i < int'(v.num); i++)
      check("dst_data", mem_rd(v.dst + AW'(i * 32)), exp_data[i]);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   d0;
    int   b0;
    int   r0;
    int   exp_launch;
    bit   idle_m;
    vec_t rv;

    vecs[0] = '{src: 32'h8000_0000, dst: 32'h8000_1000, num: 16'd1, lat: 3,   mid_start: 0, exp_lines: 16'd1};
    vecs[1] = '{src: 32'h8000_0000, dst: 32'h8000_0400, num: 16'd4, lat: 80,  mid_start: 0, exp_lines: 16'd4};
    vecs[2] = '{src: 32'hFFFF_FFE0, dst: 32'h4000_0000, num: 16'd2, lat: 2,   mid_start: 0, exp_lines: 16'd2};
    vecs[3] = '{src: 32'h1000_0008, dst: 32'h2000_0004, num: 16'd3, lat: 1,   mid_start: 0, exp_lines: 16'd3};
    vecs[4] = '{src: 32'h5000_0000, dst: 32'h6000_0000, num: 16'd5, lat: 4,   mid_start: 1, exp_lines: 16'd5};
    vecs[5] = '{src: 32'h7000_0100, dst: 32'h7100_0000, num: 16'd3, lat: 1,   mid_start: 0, exp_lines: 16'd3};
    vecs[5].lat = $urandom_range(1, 8);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", strobe_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_lines", lines_done_o, '0);
    check("rst_addr", addr_o, '0);
    check("rst_wdata", wdata_o, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // spurious done_i while idle
    r0 = req_cnt;
    spur_done = 1'b1;
    repeat (3) @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_no_req", req_cnt - r0, 0);
    check("spur_lines", lines_done_o, vecs[5].exp_lines);
    check("spur_busy", busy_o, 1'b0);

    // zero-length launch with start held for five edges
    exp_launch = 0;
    idle_m = 1;
    for (int e = 0; e < 5; e++) begin
      if (idle_m) begin
        exp_launch++;
        idle_m = 0;
      end else begin
        idle_m = 1;
      end
    end
    d0 = done_pulses;
    b0 = busy_cycles;
    r0 = req_cnt;
    @(posedge clk); #1;
    start_i     = 1'b1;
    num_lines_i = '0;
    src_addr_i  = 32'h9000_0000;
    dst_addr_i  = 32'h9100_0000;
    repeat (5) @(posedge clk);
    #1 start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("zero_no_req", req_cnt - r0, 0);
    check("zero_done_pulses", done_pulses - d0, exp_launch);
    check("zero_busy_cycles", busy_cycles - b0, exp_launch);

    // reset asserted during a write request
    launch(32'h3000_0000, 32'h3100_0000, 16'd3, 4);
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (strobe_o && rw_o && lines_done_o == 16'd1) ok = 1;
    end
    check("reached_second_wr", ok, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_strobe", strobe_o, 1'b0);
    check("async_rst_busy", busy_o, 1'b0);
    check("async_rst_lines", lines_done_o, '0);
    check("async_rst_rw", rw_o, 1'b0);
    check("async_rst_addr", addr_o, '0);
    check("async_rst_wdata", wdata_o, '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rv = '{src: 32'h3000_0000, dst: 32'h3200_0000, num: 16'd2, lat: 3, mid_start: 0, exp_lines: 16'd2};
    run_job(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
